// File: rtl/sram_like_ram_responder_if.sv
// sram_like_ram_responder_if: SRAM-like data-memory request/response bundle
//   master: ram_req/ram_we/ram_addr/ram_wdata/ram_wstrb out; addr_ok, data_ok, rdata, resp_we, outstanding in
//   slave : the mirror image, used by the responder
interface sram_like_ram_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUTSTANDING = 4
);
  logic ram_req;
  logic ram_we;
  logic [DATA_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH/8-1:0] ram_wstrb;
  logic mem_addr_ok;
  logic mem_data_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic mem_resp_we;
  logic [$clog2(OUTSTANDING+1)-1:0] outstanding;
  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
    input mem_addr_ok, mem_data_ok, mem_rdata, mem_resp_we, outstanding
  );
  modport slave (
    input ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
    output mem_addr_ok, mem_data_ok, mem_rdata, mem_resp_we, outstanding
  );
endinterface

// File: rtl/sram_like_ram_responder.sv
// sram_like_ram_responder: in-order fixed-latency responder for SRAM-like data-memory requests
//   clk, rst : clock and synchronous active-high reset
//   ram_io   : slave side of the request/response bundle (accept, data_ok pulse, read data, count)
module sram_like_ram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2,
  parameter int OUTSTANDING = 4
) (
  input logic clk,
  input logic rst,
  sram_like_ram_responder_if.slave ram_io
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int TW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int SW = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic q_we_q [OUTSTANDING];
  logic [AW-1:0] q_idx_q [OUTSTANDING];
  logic [DATA_WIDTH-1:0] q_wdata_q [OUTSTANDING];
  logic [SW-1:0] q_wstrb_q [OUTSTANDING];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic push, pop, head_we;
  logic [AW-1:0] head_idx;
  logic unused_addr_bits;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return p == PW'(OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  assign unused_addr_bits = ^{ram_io.ram_addr[1:0], ram_io.ram_addr[DATA_WIDTH-1:AW+2]};
  assign head_we = q_we_q[head_q];
  assign head_idx = q_idx_q[head_q];
  // addr_ok looks only at the registered count, so a same-cycle pop never opens a full queue
  assign ram_io.mem_addr_ok = !rst && count_q < CW'(OUTSTANDING);
  assign push = ram_io.ram_req && ram_io.mem_addr_ok;
  // the head's final latency cycle is its response cycle; reset suppresses it so discarded entries never answer
  assign pop = !rst && count_q != '0 && timer_q == TW'(LATENCY - 1);
  assign ram_io.mem_data_ok = pop;
  assign ram_io.mem_resp_we = pop && head_we;
  // in-order processing means the array already holds every earlier write when a read reaches head
  assign ram_io.mem_rdata = pop && !head_we ? mem_q[head_idx] : '0;
  assign ram_io.outstanding = count_q;
  always_comb begin
    head_d = pop ? wrap_inc(head_q) : head_q;
    tail_d = push ? wrap_inc(tail_q) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    timer_d = pop || count_q == '0 ? '0 : timer_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_we_q[tail_q] <= ram_io.ram_we;
      q_idx_q[tail_q] <= ram_io.ram_addr[2 +: AW];
      q_wdata_q[tail_q] <= ram_io.ram_wdata;
      q_wstrb_q[tail_q] <= ram_io.ram_wstrb;
    end
    if (pop && head_we)
      for (int i = 0; i < SW; i++)
        if (q_wstrb_q[head_q][i]) mem_q[head_idx][8*i +: 8] <= q_wdata_q[head_q][8*i +: 8];
  end
  assert property (@(posedge clk) disable iff (rst) !(pop && count_q == '0));
  assert property (@(posedge clk) disable iff (rst) !(push && count_q == CW'(OUTSTANDING)));
endmodule

// File: tb/tb_sram_like_ram_responder.sv
// tb_sram_like_ram_responder: randomized and directed checks of the responder against a timestamped queue model
module tb_sram_like_ram_responder;
  localparam int DW = 32;
  localparam int LAT = 2;
  localparam int OUTS = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sram_like_ram_responder_if #(.DATA_WIDTH(DW), .OUTSTANDING(OUTS)) bus ();
  sram_like_ram_responder #(.DATA_WIDTH(DW), .DEPTH(1024), .LATENCY(LAT), .OUTSTANDING(OUTS)) dut (
    .clk(clk),
    .rst(rst),
    .ram_io(bus)
  );
  typedef struct {
    int due;
    logic we;
    int idx;
    logic [31:0] wd;
    logic [3:0] ws;
  } ent_t;
  ent_t mq[$];
  logic [31:0] mm [int];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic o_aok, o_dok, o_we, e_aok, e_dok, e_we;
  logic [31:0] o_rd, e_rd;
  logic [2:0] o_out, e_out;
  function automatic logic [31:0] pv(input int i);
    return {8'hA5, 8'(i), 16'h0F00 + 16'(i)};
  endfunction
  task automatic drive(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    bus.ram_req = req;
    bus.ram_we = we;
    bus.ram_addr = addr;
    bus.ram_wdata = wd;
    bus.ram_wstrb = ws;
  endtask
  // one clock cycle: sample the DUT, derive the model's view of this cycle, then advance the model
  task automatic step();
    ent_t h;
    ent_t n;
    logic [31:0] t;
    #1;
    o_aok = bus.mem_addr_ok;
    o_dok = bus.mem_data_ok;
    o_we = bus.mem_resp_we;
    o_rd = bus.mem_rdata;
    o_out = bus.outstanding;
    e_out = 3'(mq.size());
    e_aok = !rst && mq.size() < OUTS;
    e_dok = 1'b0;
    e_we = 1'b0;
    e_rd = '0;
    if (rst) mq.delete();
    else begin
      if (mq.size() > 0 && mq[0].due == cyc) begin
        h = mq.pop_front();
        e_dok = 1'b1;
        if (h.we) begin
          e_we = 1'b1;
          t = mm[h.idx];
          for (int b = 0; b < 4; b++) if (h.ws[b]) t[8*b +: 8] = h.wd[8*b +: 8];
          mm[h.idx] = t;
        end else e_rd = mm[h.idx];
      end
      if (bus.ram_req && e_aok) begin
        n.due = (mq.size() > 0 ? mq[$].due : cyc) + LAT;
        n.we = bus.ram_we;
        n.idx = int'(bus.ram_addr[11:2]);
        n.wd = bus.ram_wdata;
        n.ws = bus.ram_wstrb;
        mq.push_back(n);
      end
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws, output int acc);
    acc = -1;
    drive(1'b1, we, addr, wd, ws);
    for (int k = 0; k < 50; k++) begin
      step();
      if (o_aok) begin
        acc = cyc - 1;
        break;
      end
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    n_tests++;
    if (acc < 0) begin
      n_fail++;
      $display("FAIL send_accept addr=%h got no addr_ok want addr_ok within 50 cycles", addr);
    end
  endtask
  task automatic wait_resp(output int c, output logic [31:0] rd, output logic w);
    c = -1;
    rd = 'x;
    w = 1'bx;
    for (int k = 0; k < 50; k++) begin
      step();
      if (o_dok) begin
        c = cyc - 1;
        rd = o_rd;
        w = o_we;
        break;
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    step();
    step();
    n_tests++;
    if ({o_aok, o_dok, o_we, o_rd, o_out} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got aok=%b dok=%b we=%b rd=%h out=%0d want all zero", o_aok, o_dok, o_we, o_rd, o_out);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if ({o_aok, o_out} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release got aok=%b out=%0d want aok=1 out=0", o_aok, o_out);
    end
  endtask
  task automatic test_preload();
    int a;
    for (int i = 0; i < 16; i++) send(1'b1, 32'(i * 4), pv(i), 4'hF, a);
    repeat (12) step();
    n_tests++;
    if (o_out !== 3'd0) begin
      n_fail++;
      $display("FAIL preload_drain got out=%0d want 0", o_out);
    end
  endtask
  task automatic test_write_read();
    int a, c;
    logic [31:0] rd;
    logic w;
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a);
    wait_resp(c, rd, w);
    n_tests++;
    if (c !== a + LAT) begin
      n_fail++;
      $display("FAIL wr_latency got cycle %0d want %0d", c, a + LAT);
    end
    n_tests++;
    if ({w, rd} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wr_resp got we=%b rd=%h want we=1 rd=0", w, rd);
    end
    send(1'b0, 32'h10, '0, '0, a);
    wait_resp(c, rd, w);
    n_tests++;
    if (c !== a + LAT) begin
      n_fail++;
      $display("FAIL rd_latency got cycle %0d want %0d", c, a + LAT);
    end
    n_tests++;
    if ({w, rd} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rd_data got we=%b rd=%h want we=0 rd=deadbeef", w, rd);
    end
  endtask
  task automatic test_partial_write();
    int a, c;
    logic [31:0] rd;
    logic w;
    send(1'b1, 32'h10, 32'h11223344, 4'b0101, a);
    wait_resp(c, rd, w);
    send(1'b0, 32'h10, '0, '0, a);
    wait_resp(c, rd, w);
    n_tests++;
    if (rd !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL partial_write got rd=%h want de22be44", rd);
    end
  endtask
  task automatic test_alias();
    int a, c;
    logic [31:0] rd;
    logic w;
    send(1'b0, 32'h1010, '0, '0, a);
    wait_resp(c, rd, w);
    n_tests++;
    if ({w, rd} !== {1'b0, 32'hDE22BE44}) begin
      n_fail++;
      $display("FAIL alias_read got we=%b rd=%h want we=0 rd=de22be44", w, rd);
    end
  endtask
  task automatic test_back_to_back_raw();
    int a1, a2, c1, c2;
    logic [31:0] v, rd;
    logic w;
    v = $urandom();
    send(1'b1, 32'h80, v, 4'hF, a1);
    send(1'b0, 32'h80, '0, '0, a2);
    n_tests++;
    if (a2 !== a1 + 1) begin
      n_fail++;
      $display("FAIL raw_accept got read accepted cycle %0d want %0d", a2, a1 + 1);
    end
    wait_resp(c1, rd, w);
    wait_resp(c2, rd, w);
    n_tests++;
    if ({w, rd} !== {1'b0, v}) begin
      n_fail++;
      $display("FAIL raw_data got we=%b rd=%h want we=0 rd=%h", w, rd, v);
    end
    n_tests++;
    if (c2 - c1 !== LAT) begin
      n_fail++;
      $display("FAIL raw_spacing got %0d want %0d", c2 - c1, LAT);
    end
  endtask
  task automatic test_backpressure();
    int acc, nresp, maxo;
    int rc[$];
    logic [31:0] rv[$];
    acc = 0;
    nresp = 0;
    maxo = 0;
    for (int k = 0; k < 100 && nresp < 8; k++) begin
      drive(acc < 8, 1'b0, 32'((8 + acc) * 4), '0, '0);
      step();
      n_tests++;
      if ({o_aok, o_dok, o_we, o_rd, o_out} !== {e_aok, e_dok, e_we, e_rd, e_out}) begin
        n_fail++;
        $display("FAIL bp_cycle cyc=%0d got aok=%b dok=%b we=%b rd=%h out=%0d want aok=%b dok=%b we=%b rd=%h out=%0d",
                 cyc - 1, o_aok, o_dok, o_we, o_rd, o_out, e_aok, e_dok, e_we, e_rd, e_out);
      end
      if (bus.ram_req && o_aok) acc++;
      if (int'(o_out) > maxo) maxo = int'(o_out);
      if (o_dok) begin
        rc.push_back(cyc - 1);
        rv.push_back(o_rd);
        nresp++;
      end
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    n_tests++;
    if (nresp !== 8) begin
      n_fail++;
      $display("FAIL bp_count got %0d responses want 8", nresp);
    end
    n_tests++;
    if (maxo !== OUTS) begin
      n_fail++;
      $display("FAIL bp_max_outstanding got %0d want %0d", maxo, OUTS);
    end
    for (int i = 0; i < rv.size(); i++) begin
      n_tests++;
      if (rv[i] !== pv(8 + i)) begin
        n_fail++;
        $display("FAIL bp_order resp %0d got %h want %h", i, rv[i], pv(8 + i));
      end
      if (i > 0) begin
        n_tests++;
        if (rc[i] - rc[i-1] !== LAT) begin
          n_fail++;
          $display("FAIL bp_spacing resp %0d got %0d want %0d", i, rc[i] - rc[i-1], LAT);
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    int a, c;
    logic [31:0] rd;
    logic w;
    logic stray;
    send(1'b0, 32'h20, '0, '0, a);
    send(1'b0, 32'h24, '0, '0, a);
    send(1'b1, 32'h28, 32'h0BAD0BAD, 4'hF, a);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_tests++;
    if ({o_aok, o_out} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midreset_state got aok=%b out=%0d want aok=1 out=0", o_aok, o_out);
    end
    stray = 1'b0;
    repeat (12) begin
      step();
      stray = stray | o_dok;
    end
    n_tests++;
    if (stray !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_stray got data_ok=%b want 0", stray);
    end
    send(1'b0, 32'h28, '0, '0, a);
    wait_resp(c, rd, w);
    n_tests++;
    if (rd !== pv(10)) begin
      n_fail++;
      $display("FAIL midreset_discard got rd=%h want %h", rd, pv(10));
    end
    send(1'b0, 32'h10, '0, '0, a);
    wait_resp(c, rd, w);
    n_tests++;
    if (rd !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL midreset_keep got rd=%h want de22be44", rd);
    end
  endtask
  task automatic test_random();
    logic [31:0] addr;
    for (int k = 0; k < 320; k++) begin
      addr = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      if (k < 300) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom(), 4'($urandom_range(0, 15)));
      else drive(1'b0, 1'b0, '0, '0, '0);
      step();
      n_tests++;
      if ({o_aok, o_dok, o_we, o_rd, o_out} !== {e_aok, e_dok, e_we, e_rd, e_out}) begin
        n_fail++;
        $display("FAIL rand_cycle cyc=%0d got aok=%b dok=%b we=%b rd=%h out=%0d want aok=%b dok=%b we=%b rd=%h out=%0d",
                 cyc - 1, o_aok, o_dok, o_we, o_rd, o_out, e_aok, e_dok, e_we, e_rd, e_out);
      end
    end
  endtask
  initial begin
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    test_reset();
    test_preload();
    test_write_read();
    test_partial_write();
    test_alias();
    test_back_to_back_raw();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before 500000 time units");
    $fatal(1, "watchdog");
  end
endmodule
